// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit direction counters and a
// speculative return-address stack. IF1_pc is looked up combinationally and
// the prediction is registered into IF2; EX trains the BTB and repairs the RAS.
module branch_predictor #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 64,
  parameter int RAS_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [XLEN-1:0]              IF1_pc,
  input  logic                         IF1_stall,
  input  logic                         IF2_Flush,
  output logic                         IF2_BTBhit,
  output logic [1:0]                   IF2_branch_prediction,
  output logic [1:0]                   IF2_type,
  output logic [XLEN-1:0]              IF2_pc_imm,
  output logic [$clog2(RAS_DEPTH)-1:0] IF2_ras_ptr,
  input  logic                         EX_update,
  input  logic [XLEN-1:0]              EX_pc,
  input  logic [XLEN-1:0]              EX_target,
  input  logic                         EX_taken,
  input  logic [1:0]                   EX_type,
  input  logic                         EX_mispredict,
  input  logic [$clog2(RAS_DEPTH)-1:0] EX_ras_ptr
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam int RAS_W = $clog2(RAS_DEPTH);

  localparam logic [1:0] T_COND   = 2'b00;
  localparam logic [1:0] T_CALL   = 2'b10;
  localparam logic [1:0] T_RETURN = 2'b11;

  // BTB storage, one field array per entry component
  logic             btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_target [BTB_ENTRIES];
  logic [1:0]       btb_type   [BTB_ENTRIES];
  logic [1:0]       btb_ctr    [BTB_ENTRIES];

  // Speculative return-address stack; ras_ptr addresses the current top
  logic [XLEN-1:0]  ras [RAS_DEPTH];
  logic [RAS_W-1:0] ras_ptr;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [1:0]       lk_type;
  logic [1:0]       lk_ctr;
  logic [XLEN-1:0]  lk_target;
  logic             lk_accept;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             repair;

  // Counter update on a resolved instruction that hits its entry
  function automatic logic [1:0] ctr_train(input logic [1:0] ctr,
                                           input logic [1:0] typ,
                                           input logic       taken);
    if (typ != T_COND) return 2'b11;
    if (taken)         return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

  // Initial counter for a freshly allocated (taken) entry
  function automatic logic [1:0] ctr_alloc(input logic [1:0] typ);
    return (typ == T_COND) ? 2'b10 : 2'b11;
  endfunction

  // Lookup of IF1_pc against the pre-update arrays; returns read the RAS top
  always_comb begin
    lk_idx    = IF1_pc[IDX_W+1:2];
    lk_tag    = IF1_pc[XLEN-1:IDX_W+2];
    lk_hit    = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    lk_type   = btb_type[lk_idx];
    lk_ctr    = btb_ctr[lk_idx];
    lk_target = (lk_type == T_RETURN) ? ras[ras_ptr] : btb_target[lk_idx];
    lk_accept = !IF2_Flush && !IF1_stall;
    ex_idx    = EX_pc[IDX_W+1:2];
    ex_tag    = EX_pc[XLEN-1:IDX_W+2];
    ex_hit    = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
    repair    = EX_update && EX_mispredict;
  end

  // IF1 -> IF2 stage boundary: flush clears the hit, stall holds everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF2_BTBhit            <= 1'b0;
      IF2_branch_prediction <= 2'b01;
      IF2_type              <= 2'b00;
      IF2_pc_imm            <= '0;
      IF2_ras_ptr           <= '0;
    end else if (IF2_Flush) begin
      IF2_BTBhit <= 1'b0;
    end else if (!IF1_stall) begin
      IF2_BTBhit  <= lk_hit;
      IF2_ras_ptr <= ras_ptr;
      if (lk_hit) begin
        IF2_branch_prediction <= lk_ctr;
        IF2_type              <= lk_type;
        IF2_pc_imm            <= lk_target;
      end
    end
  end

  // RAS: EX repair restores the checkpoint and replays the op, otherwise speculate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else if (repair) begin
      if (EX_type == T_CALL) begin
        ras[EX_ras_ptr + RAS_W'(1)] <= EX_pc + XLEN'(4);
        ras_ptr                     <= EX_ras_ptr + RAS_W'(1);
      end else if (EX_type == T_RETURN) begin
        ras_ptr <= EX_ras_ptr - RAS_W'(1);
      end else begin
        ras_ptr <= EX_ras_ptr;
      end
    end else if (lk_accept && lk_hit) begin
      if (lk_type == T_CALL) begin
        ras[ras_ptr + RAS_W'(1)] <= IF1_pc + XLEN'(4);
        ras_ptr                  <= ras_ptr + RAS_W'(1);
      end else if (lk_type == T_RETURN) begin
        ras_ptr <= ras_ptr - RAS_W'(1);
      end
    end
  end

  // BTB training: update a hitting entry, allocate on a taken miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_type[i]   <= 2'b00;
        btb_ctr[i]    <= 2'b01;
      end
    end else if (EX_update) begin
      if (ex_hit) begin
        btb_target[ex_idx] <= EX_target;
        btb_type[ex_idx]   <= EX_type;
        btb_ctr[ex_idx]    <= ctr_train(btb_ctr[ex_idx], EX_type, EX_taken);
      end else if (EX_taken) begin
        btb_valid[ex_idx]  <= 1'b1;
        btb_tag[ex_idx]    <= ex_tag;
        btb_target[ex_idx] <= EX_target;
        btb_type[ex_idx]   <= EX_type;
        btb_ctr[ex_idx]    <= ctr_alloc(EX_type);
      end
    end
  end

endmodule
